// File: rtl/counter_sched_pkg.sv
// rtl/counter_sched_pkg.sv - shared types and constants for the counter scheduler
package counter_sched_pkg;

    localparam int WIDTH_DEFAULT = 4;
    localparam int N_REQ         = 2;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/counter_core.sv
// rtl/counter_core.sv - shared count register with synchronous clear and enable
module counter_core
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             clear,
    input  logic             enable,
    output logic [WIDTH-1:0] count
);

    // Clear wins over enable so reset and IDLE entry always land on zero.
    always_ff @(posedge clk) begin
        if (clear) begin
            count <= '0;
        end else if (enable) begin
            count <= count + 1'b1;
        end
    end

endmodule

// File: rtl/counter_sched.sv
// rtl/counter_sched.sv - two-requester round-robin owner of a shared terminal counter
module counter_sched
    import counter_sched_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [N_REQ-1:0] req,
    input  logic [WIDTH-1:0] len0,
    input  logic [WIDTH-1:0] len1,
    output logic [N_REQ-1:0] grant,
    output logic [N_REQ-1:0] done,
    output logic             busy,
    output logic [WIDTH-1:0] count
);

    state_t             state, state_next;
    logic [N_REQ-1:0]   grant_next, done_next;
    logic [WIDTH-1:0]   target, target_next;
    logic               last, last_next;
    logic               win;
    logic               clear, enable;

    counter_core #(.WIDTH(WIDTH)) u_core (
        .clk    (clk),
        .clear  (clear),
        .enable (enable),
        .count  (count)
    );

    always_comb begin
        state_next  = state;
        grant_next  = grant;
        done_next   = '0;
        target_next = target;
        last_next   = last;
        clear       = 1'b0;
        enable      = 1'b0;
        // last holds the index granted most recently; a tie goes to the other one
        win         = (req == 2'b11) ? ~last : req[1];

        unique case (state)
            IDLE: begin
                clear = 1'b1;
                if (|req) begin
                    state_next  = RUN;
                    grant_next  = win ? 2'b10 : 2'b01;
                    target_next = win ? len1 : len0;
                    last_next   = win;
                end
            end
            RUN: begin
                if (!req[grant[1]]) begin
                    state_next = IDLE;
                    grant_next = '0;
                    clear      = 1'b1;
                end else if (count == target) begin
                    state_next = DONE;
                    done_next  = grant;
                end else begin
                    enable = 1'b1;
                end
            end
            DONE: begin
                state_next = IDLE;
                grant_next = '0;
                clear      = 1'b1;
            end
            default: begin
                state_next = IDLE;
                grant_next = '0;
                clear      = 1'b1;
            end
        endcase

        if (!reset) begin
            clear  = 1'b1;
            enable = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state  <= IDLE;
            grant  <= '0;
            done   <= '0;
            busy   <= 1'b0;
            target <= '0;
            last   <= 1'b1;
        end else begin
            state  <= state_next;
            grant  <= grant_next;
            done   <= done_next;
            busy   <= (state_next != IDLE);
            target <= target_next;
            last   <= last_next;
        end
    end

endmodule

// File: doc/counter_sched.md
COUNTER_SCHED -- requirements
Module: counter_sched

Interface
REQ-001 Parameter: WIDTH, 4, bit width of the shared count, the length inputs and the count output.
REQ-002 clk  input  1  single clock; all state changes on rising edge.
REQ-003 reset  input  1  synchronous, active-low reset; sampled on rising edge of clk; no asynchronous path.
REQ-004 req  input  2  per-requester request; bit i high = requester i wants the counter.
REQ-005 len0  input  WIDTH  terminal count for requester 0; sampled only at grant.
REQ-006 len1  input  WIDTH  terminal count for requester 1; sampled only at grant.
REQ-007 grant  output  2  one-hot owner of the counter; 00 when IDLE.
REQ-008 done  output  2  one-cycle completion pulse to the granted requester.
REQ-009 busy  output  1  high in RUN and DONE.
REQ-010 count  output  WIDTH  current shared count value; 0 in IDLE.

Function
REQ-011 FSM states: IDLE, RUN, DONE; all outputs are registered.
REQ-012 IDLE: no req bit high -> stay IDLE; any req high -> RUN next edge, grant set to the winner, count cleared to 0, target latched from the winner's len.
REQ-013 Arbitration: single req wins outright; both high -> winner is the requester not granted last (round-robin pointer).
REQ-014 Pointer updates at each grant; after reset requester 0 wins a tie.
REQ-015 RUN: count increments by 1 each edge while count != target.
REQ-016 RUN: count == target at an edge -> DONE; count holds at target.
REQ-017 RUN lasts target+1 cycles (count values 0..target); target = 0 gives one RUN cycle.
REQ-018 Count never wraps: count stops at target, and target <= 2^WIDTH-1.
REQ-019 DONE: lasts exactly one cycle; done[granted] = 1, grant held; DONE -> IDLE unconditionally.
REQ-020 IDLE entry from DONE or abort: grant = 00, count = 0, done = 00, busy = 0.
REQ-021 Abort: req[granted] low at a RUN edge -> IDLE next edge; no done pulse; pointer keeps the aborted grant.
REQ-022 req changes during DONE are ignored; the done pulse always completes.
REQ-023 len0/len1 changes after the grant edge have no effect on the current run.
REQ-024 Non-granted req during RUN/DONE is held off; it is arbitrated in the next IDLE cycle.
REQ-025 Minimum gap: one IDLE cycle between DONE and the next RUN.
REQ-026 done is never high outside DONE; at most one done bit is high.

Reset
REQ-027 reset low at an edge -> next state IDLE, regardless of current state.
REQ-028 On reset: grant = 00, done = 00, busy = 0, count = 0, target = 0, pointer = favour requester 0.
REQ-029 Reset mid-RUN produces no done pulse; operation resumes from IDLE on the first edge with reset high.

Structure
REQ-030 Shared package counter_sched_pkg holds the state enum (IDLE/RUN/DONE), WIDTH default and requester count constant (2).
REQ-031 Sub-module counter_core holds the WIDTH-bit count register with synchronous clear and enable inputs and a count output; the FSM drives clear/enable and performs the terminal compare.

Verification
REQ-032 Reset low 2 cycles, req=11 -> all outputs 0 during reset; first edge after release grant=01, count=0.
REQ-033 req=01, len0=3 held -> RUN with count 0,1,2,3 over 4 cycles, then done=01 for 1 cycle, then grant=00, count=0.
REQ-034 req=11 held continuously, len0=1, len1=2 -> grants alternate 01,10,01 with one IDLE cycle between runs; done bits match the grants.
REQ-035 req=10, len1=0 -> one RUN cycle with count=0, next cycle done=10, next cycle IDLE.
REQ-036 req0 granted with len0=10, req0 dropped when count=4 -> IDLE next edge, done never pulses; pending req1 granted on the following edge.
REQ-037 len0=15, reset asserted when count=7 -> next edge all outputs 0, no done; len0 changed to 2 mid-run in a separate run -> run still ends at count 15.
